bcd_adder_serial: RTL and testbench

Parametrised, digit-serial, multi-digit packed-BCD adder. It processes one BCD digit per clock, least significant digit first, and carries ripple between digits through a register. It replaces single-digit combinational BCD addition in datapaths needing wide decimal operands. Valid/ready handshakes are used on both the input and output sides.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 28 ++
 rtl/bcd_adder_serial.sv | 134 +++++++++++++
 tb/tb_bcd_adder_serial.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared FSM state type, BCD constants and the nines-complement helper for the serial BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // An out-of-range digit has no meaningful complement; 9 keeps the sum bounded and err flags it.
    function automatic logic [3:0] bcd_nines(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : (BCD_MAX - digit);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit plus carry, purely combinational; decimal-adjusts raw binary sums above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c_in,
    output logic [3:0] d,
    output logic       c_out,
    output logic       bad
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c_in};
        if (s > {1'b0, BCD_MAX}) begin
            d     = s[3:0] + BCD_CORR;
            c_out = 1'b1;
        end else begin
            d     = s[3:0];
            c_out = 1'b0;
        end
    end

    assign bad = (a_d > BCD_MAX) | (b_d > BCD_MAX);

endmodule

// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder, LSD first; result valid DIGITS edges after accept, held in DONE until out_ready.
// Optional BCD_ADDER_SERIAL_SUB_EN adds a sub port for a - b via nines complement with forced carry-in.
module bcd_adder_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
`ifdef BCD_ADDER_SERIAL_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res_sh;
    logic [W-1:0]     res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             err_acc;
    logic [3:0]       b_d;
    logic [3:0]       d;
    logic             c_out;
    logic             bad;
    logic             dig_bad;
    logic             last;
`ifdef BCD_ADDER_SERIAL_SUB_EN
    logic             sub_r;
`endif

    // The digit adder only sees the complemented b, so the raw b digit is range-checked here too.
    always_comb begin
`ifdef BCD_ADDER_SERIAL_SUB_EN
        b_d     = sub_r ? bcd_nines(b_sh[3:0]) : b_sh[3:0];
        dig_bad = bad | (b_sh[3:0] > BCD_MAX);
`else
        b_d     = b_sh[3:0];
        dig_bad = bad;
`endif
    end

    bcd_digit_add u_digit (
        .a_d   (a_sh[3:0]),
        .b_d   (b_d),
        .c_in  (carry),
        .d     (d),
        .c_out (c_out),
        .bad   (bad)
    );

    generate
        if (DIGITS == 1) begin : g_one
            assign res_next = d;
        end else begin : g_many
            assign res_next = {d, res_sh[W-1:4]};
        end
    endgenerate

    assign last      = (cnt == CNT_W'(DIGITS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            err_acc <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
`ifdef BCD_ADDER_SERIAL_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        cnt     <= '0;
                        err_acc <= 1'b0;
`ifdef BCD_ADDER_SERIAL_SUB_EN
                        sub_r   <= sub;
                        carry   <= sub | cin;
`else
                        carry   <= cin;
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    res_sh  <= res_next;
                    carry   <= c_out;
                    err_acc <= err_acc | dig_bad;
                    cnt     <= cnt + CNT_W'(1);
                    if (last) begin
                        sum   <= res_next;
                        cout  <= c_out;
                        err   <= err_acc | dig_bad;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Directed plus small random checks of bcd_adder_serial with DIGITS=4 using a decimal-integer scoreboard.
module tb_bcd_adder_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef BCD_ADDER_SERIAL_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    bcd_adder_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef BCD_ADDER_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int           x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: plain decimal arithmetic, valid digits only.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sv);
        exp_t e;
        int   lim = 10 ** DIGITS;
        int   tot;
        if (sv) tot = bcd2int(av) + (lim - 1 - bcd2int(bv)) + 1;
        else    tot = bcd2int(av) + bcd2int(bv) + int'(ci);
        e.s = int2bcd(tot % lim);
        e.c = (tot >= lim);
        e.e = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sv, input exp_t e);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = ci;
`ifdef BCD_ADDER_SERIAL_SUB_EN
        sub      = sv;
`endif
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 0);
    endtask

    task automatic wait_result();
        int   lat = 0;
        exp_t e;
        while (out_valid !== 1'b1 && lat < DIGITS + 8) begin
            step();
            lat++;
        end
        chk("out_valid", out_valid, 1);
        chk("latency", lat, DIGITS);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
            chk("err", err, e.e);
        end
    endtask

    task automatic drain();
        step();
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sv, input exp_t e);
        accept(av, bv, ci, sv, e);
        wait_result();
        drain();
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef BCD_ADDER_SERIAL_SUB_EN
        sub       = 1'b0;
`endif
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        op(16'h1234, 16'h4321, 1'b0, 1'b0, model(16'h1234, 16'h4321, 1'b0, 1'b0));
        op(16'h9999, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0});
        op(16'h9999, 16'h9999, 1'b1, 1'b0, '{16'h9999, 1'b1, 1'b0});
        // Raw-binary rule on digit 2: 10 -> 0 with carry into digit 3.
        op(16'h0A00, 16'h0000, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b1});
        op(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});

        out_ready = 1'b0;
        accept(16'h0123, 16'h0456, 1'b0, 1'b0, model(16'h0123, 16'h0456, 1'b0, 1'b0));
        wait_result();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, 16'h0579);
            chk("bp_cout", cout, 0);
            chk("bp_err", err, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("idle_sum_hold", sum, 16'h0579);

        accept(16'h0777, 16'h0111, 1'b0, 1'b0, model(16'h0777, 16'h0111, 1'b0, 1'b0));
        step();
        step();
        chk("run_sum_hold", sum, 16'h0579);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        op(16'h0005, 16'h0005, 1'b0, 1'b0, '{16'h0010, 1'b0, 1'b0});

        for (int i = 0; i < 6; i++) begin
            ra = int2bcd(int'($urandom_range(0, 9999)));
            rb = int2bcd(int'($urandom_range(0, 9999)));
            rc = 1'($urandom_range(0, 1));
            op(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
        end

`ifdef BCD_ADDER_SERIAL_SUB_EN
        op(16'h0050, 16'h0025, 1'b0, 1'b1, '{16'h0025, 1'b1, 1'b0});
        op(16'h0025, 16'h0050, 1'b0, 1'b1, '{16'h9975, 1'b0, 1'b0});
        op(16'h0300, 16'h0100, 1'b1, 1'b1, model(16'h0300, 16'h0100, 1'b1, 1'b1));
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
